// File: rtl/regset_pkg.sv
// Shared definitions for the register-set write/bypass front end.
package regset_pkg;

    localparam int REGSET_ADDR_W = 6;
    localparam int REGSET_DATA_W = 32;

    // Controller state: INIT sweeps every entry to zero, RUN serves the pipeline.
    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } regset_state_e;

endpackage

// File: rtl/regset_bypass.sv
// One read port's read-during-write correction. The BRAM returns stale data
// when the read and the write address collide on the same edge, so the written
// value is captured alongside a hit flag and substituted on the next cycle.
module regset_bypass
    import regset_pkg::*;
#(
    parameter int ADDR_W = REGSET_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_done_i,
    input  logic                     we_i,
    input  logic [ADDR_W-1:0]        wa_i,
    input  logic [REGSET_DATA_W-1:0] wd_i,
    input  logic                     wg_i,
    input  logic [ADDR_W-1:0]        ra_i,
    input  logic [REGSET_DATA_W-1:0] rd_i,
    input  logic                     rg_i,
    output logic [REGSET_DATA_W-1:0] q_o,
    output logic                     qg_o
);

    logic                     hit_q;
    logic [REGSET_DATA_W-1:0] bd_q;
    logic                     bg_q;

    // Capture the write that lands on the address being read this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q <= 1'b0;
            bd_q  <= '0;
            bg_q  <= 1'b0;
        end else begin
            hit_q <= we_i & (wa_i == ra_i);
            bd_q  <= wd_i;
            bg_q  <= wg_i;
        end
    end

    // Hide contents until the sweep is done, otherwise prefer the captured write.
    always_comb begin
        q_o  = '0;
        qg_o = 1'b0;
        if (init_done_i) begin
            q_o  = hit_q ? bd_q : rd_i;
            qg_o = hit_q ? bg_q : rg_i;
        end
    end

endmodule

// File: rtl/regset_writer.sv
// Write-port controller and read-bypass front end for a RegSet instance.
// After reset every entry is swept to zero (for BRAMs without preinit), then
// pipeline writebacks are passed combinationally onto the single write port.
// Handshake: a writeback transfers on any cycle where wb_valid && wb_ready;
// the requester holds wb_valid and its payload stable until that happens.
module regset_writer
    import regset_pkg::*;
#(
    parameter int NUM_REGS    = 64,
    parameter int ADDR_W      = REGSET_ADDR_W,
    parameter int INIT_GRUBBY = 0,
    parameter int PROTECT_X0  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    output logic                     init_done,
    input  logic                     wb_valid,
    output logic                     wb_ready,
    input  logic [ADDR_W-1:0]        wb_addr,
    input  logic [REGSET_DATA_W-1:0] wb_data,
    input  logic                     wb_grubby,
    input  logic [ADDR_W-1:0]        rd_addr1,
    input  logic [ADDR_W-1:0]        rd_addr2,
    output logic [REGSET_DATA_W-1:0] q1,
    output logic [REGSET_DATA_W-1:0] q2,
    output logic                     qg1,
    output logic                     qg2,
    output logic                     rs_we,
    output logic [ADDR_W-1:0]        rs_wa,
    output logic [REGSET_DATA_W-1:0] rs_wd,
    output logic                     rs_wg,
    output logic [ADDR_W-1:0]        rs_ra1,
    output logic [ADDR_W-1:0]        rs_ra2,
    input  logic [REGSET_DATA_W-1:0] rs_rd1,
    input  logic                     rs_rg1,
    input  logic [REGSET_DATA_W-1:0] rs_rd2,
    input  logic                     rs_rg2
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);
    localparam logic              SWEEP_G   = (INIT_GRUBBY != 0);
    localparam logic              GUARD_X0  = (PROTECT_X0 != 0);

    regset_state_e     state_q;
    logic [ADDR_W-1:0] cnt_q;

    // Sweep sequencer: INIT walks cnt over every entry, RUN waits for clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (clear) begin
                        state_q <= INIT;
                        cnt_q   <= '0;
                    end
                end
                default: begin
                    state_q <= INIT;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign init_done = (state_q == RUN);
    assign wb_ready  = init_done;
    assign rs_ra1    = rd_addr1;
    assign rs_ra2    = rd_addr2;

    // Write-port mux: sweep owns the port in INIT, writeback owns it in RUN.
    always_comb begin
        rs_we = 1'b0;
        rs_wa = '0;
        rs_wd = '0;
        rs_wg = 1'b0;
        if (state_q == INIT) begin
            rs_we = 1'b1;
            rs_wa = cnt_q;
            rs_wg = (cnt_q == '0) ? 1'b0 : SWEEP_G;
        end else begin
            rs_we = wb_valid & ~(GUARD_X0 & (wb_addr == '0));
            rs_wa = wb_addr;
            rs_wd = wb_data;
            rs_wg = wb_grubby;
        end
    end

    regset_bypass #(.ADDR_W(ADDR_W)) u_byp1 (
        .clk         (clk),
        .rst         (rst),
        .init_done_i (init_done),
        .we_i        (rs_we),
        .wa_i        (rs_wa),
        .wd_i        (rs_wd),
        .wg_i        (rs_wg),
        .ra_i        (rd_addr1),
        .rd_i        (rs_rd1),
        .rg_i        (rs_rg1),
        .q_o         (q1),
        .qg_o        (qg1)
    );

    regset_bypass #(.ADDR_W(ADDR_W)) u_byp2 (
        .clk         (clk),
        .rst         (rst),
        .init_done_i (init_done),
        .we_i        (rs_we),
        .wa_i        (rs_wa),
        .wd_i        (rs_wd),
        .wg_i        (rs_wg),
        .ra_i        (rd_addr2),
        .rd_i        (rs_rd2),
        .rg_i        (rs_rg2),
        .q_o         (q2),
        .qg_o        (qg2)
    );

endmodule

// File: tb/tb_regset_writer.sv
// Directed bench for regset_writer, with a behavioural RegSet model that has
// a 1-cycle registered read returning stale data on read-during-write.
module tb_regset_writer;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          clear;
    logic          init_done;
    logic          wb_valid;
    logic          wb_ready;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          wb_grubby;
    logic [AW-1:0] rd_addr1;
    logic [AW-1:0] rd_addr2;
    logic [DW-1:0] q1;
    logic [DW-1:0] q2;
    logic          qg1;
    logic          qg2;
    logic          rs_we;
    logic [AW-1:0] rs_wa;
    logic [DW-1:0] rs_wd;
    logic          rs_wg;
    logic [AW-1:0] rs_ra1;
    logic [AW-1:0] rs_ra2;
    logic [DW-1:0] rs_rd1;
    logic          rs_rg1;
    logic [DW-1:0] rs_rd2;
    logic          rs_rg2;

    int n_checks = 0;
    int n_errors = 0;
    logic fill;

    // Clock / reset block
    always #5 clk = ~clk;

    regset_writer #(
        .NUM_REGS    (64),
        .ADDR_W      (AW),
        .INIT_GRUBBY (1),
        .PROTECT_X0  (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .init_done (init_done),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .wb_grubby (wb_grubby),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .q1        (q1),
        .q2        (q2),
        .qg1       (qg1),
        .qg2       (qg2),
        .rs_we     (rs_we),
        .rs_wa     (rs_wa),
        .rs_wd     (rs_wd),
        .rs_wg     (rs_wg),
        .rs_ra1    (rs_ra1),
        .rs_ra2    (rs_ra2),
        .rs_rd1    (rs_rd1),
        .rs_rg1    (rs_rg1),
        .rs_rd2    (rs_rd2),
        .rs_rg2    (rs_rg2)
    );

    // RegSet model: read-before-write BRAM; 'fill' loads non-zero garbage.
    logic [DW-1:0] mem_d [64];
    logic          mem_g [64];

    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 64; i++) begin
                mem_d[i] <= 32'hBAD0_0000 | i;
                mem_g[i] <= 1'b1;
            end
            rs_rd1 <= '0;
            rs_rg1 <= 1'b0;
            rs_rd2 <= '0;
            rs_rg2 <= 1'b0;
        end else begin
            rs_rd1 <= mem_d[rs_ra1];
            rs_rg1 <= mem_g[rs_ra1];
            rs_rd2 <= mem_d[rs_ra2];
            rs_rg2 <= mem_g[rs_ra2];
            if (rs_we) begin
                mem_d[rs_wa] <= rs_wd;
                mem_g[rs_wa] <= rs_wg;
            end
        end
    end

    // Scoreboard check
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Driver: advance to just after the next active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expect n sweep cycles starting at cnt=0; called just after an edge.
    task automatic run_sweep(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("sweep_we", rs_we, 1);
            chk("sweep_wa", rs_wa, i);
            chk("sweep_wd", rs_wd, 0);
            chk("sweep_wg", rs_wg, (i == 0) ? 0 : 1);
            chk("sweep_done_rdy", {init_done, wb_ready}, 0);
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; fill = 1'b1; clear = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; wb_data = '0; wb_grubby = 1'b0;
        rd_addr1 = 6'd63; rd_addr2 = 6'd62;

        // Reset values
        tick();
        fill = 1'b0;
        tick();
        @(negedge clk);
        chk("rst_init_done", init_done, 0);
        chk("rst_wb_ready", wb_ready, 0);
        chk("rst_q1", q1, 0);
        chk("rst_q2", q2, 0);
        chk("rst_qg", {qg1, qg2}, 0);
        tick();

        // Sweep after reset: 64 cycles, RUN on cycle 65
        rst = 1'b0;
        run_sweep(64);
        @(negedge clk);
        chk("run_init_done", init_done, 1);
        chk("run_wb_ready", wb_ready, 1);
        // Last sweep write to x63 bypasses the stale BRAM garbage
        chk("sweep_byp_q1", q1, 0);
        chk("sweep_byp_qg1", qg1, 1);
        chk("x62_q2", q2, 0);
        chk("x62_qg2", qg2, 1);
        chk("ra1_pass", rs_ra1, 63);
        tick();

        // Read x5 and x0 after sweep with INIT_GRUBBY=1
        rd_addr1 = 6'd5; rd_addr2 = 6'd0;
        tick();
        @(negedge clk);
        chk("x5_q", q1, 0);
        chk("x5_qg", qg1, 1);
        chk("x0_q", q2, 0);
        chk("x0_qg", qg2, 0);

        // Read-during-write on x7
        tick();
        wb_valid = 1'b1; wb_addr = 6'd7; wb_data = 32'hDEAD_BEEF; wb_grubby = 1'b1;
        rd_addr1 = 6'd7;
        @(negedge clk);
        chk("wb7_we", rs_we, 1);
        chk("wb7_wa", rs_wa, 7);
        chk("wb7_wd", rs_wd, 32'hDEAD_BEEF);
        chk("wb7_wg", rs_wg, 1);
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        chk("rdw7_q1", q1, 32'hDEAD_BEEF);
        chk("rdw7_qg1", qg1, 1);
        tick();
        @(negedge clk);
        chk("bram7_q1", q1, 32'hDEAD_BEEF);
        chk("bram7_qg1", qg1, 1);

        // Writeback to x0 is dropped
        tick();
        wb_valid = 1'b1; wb_addr = 6'd0; wb_data = 32'h1234_5678; wb_grubby = 1'b1;
        rd_addr1 = 6'd0; rd_addr2 = 6'd0;
        @(negedge clk);
        chk("x0_we", rs_we, 0);
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        chk("x0w_q1", q1, 0);
        chk("x0w_q2", q2, 0);
        chk("x0w_qg", {qg1, qg2}, 0);

        // Write x9 while reading x7 on port 2: no hit, BRAM data passes
        tick();
        wb_valid = 1'b1; wb_addr = 6'd9; wb_data = 32'h0000_1111; wb_grubby = 1'b0;
        rd_addr1 = 6'd5; rd_addr2 = 6'd7;
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        chk("nohit_q2", q2, 32'hDEAD_BEEF);
        chk("nohit_q1", q1, 0);

        // Both ports hit the same write
        tick();
        wb_valid = 1'b1; wb_addr = 6'd10; wb_data = 32'h0000_CAFE; wb_grubby = 1'b1;
        rd_addr1 = 6'd10; rd_addr2 = 6'd10;
        tick();
        wb_valid = 1'b0;
        @(negedge clk);
        chk("dual_q1", q1, 32'h0000_CAFE);
        chk("dual_q2", q2, 32'h0000_CAFE);
        chk("dual_qg", {qg1, qg2}, 2'b11);

        // Writeback plus clear in the same cycle, then a full re-sweep
        tick();
        wb_valid = 1'b1; wb_addr = 6'd3; wb_data = 32'h0000_00A5; wb_grubby = 1'b0;
        clear = 1'b1; rd_addr1 = 6'd3; rd_addr2 = 6'd9;
        @(negedge clk);
        chk("clr_we", rs_we, 1);
        chk("clr_wa", rs_wa, 3);
        chk("clr_wd", rs_wd, 32'h0000_00A5);
        chk("clr_rdy", wb_ready, 1);
        tick();
        clear = 1'b0; wb_valid = 1'b0;
        run_sweep(64);
        @(negedge clk);
        chk("clr_done", init_done, 1);
        chk("x3_q", q1, 0);
        chk("x3_qg", qg1, 1);
        chk("x9_q", q2, 0);

        // Reset in mid-sweep with a writeback held throughout
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        wb_valid = 1'b1; wb_addr = 6'd12; wb_data = 32'h0000_600D; wb_grubby = 1'b0;
        run_sweep(30);
        rst = 1'b1;
        @(negedge clk);
        chk("rst30_wa", rs_wa, 30);
        tick();
        rst = 1'b0;
        run_sweep(64);
        @(negedge clk);
        chk("held_rdy", wb_ready, 1);
        chk("held_we", rs_we, 1);
        chk("held_wa", rs_wa, 12);
        chk("held_wd", rs_wd, 32'h0000_600D);
        tick();
        wb_valid = 1'b0; rd_addr1 = 6'd12;
        tick();
        @(negedge clk);
        chk("x12_q", q1, 32'h0000_600D);
        chk("x12_qg", qg1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
